mac_vector_feeder: RTL and testbench

Upstream stage of the fixed-point MAC unit: buffers incoming operand pairs in a small FIFO and streams one vector of `vec_len` pairs into the MAC per `start` command. Clears the MAC accumulator before each vector and strobes each operand pair. After the MAC pipeline drains, captures the 16-bit dot-product result and presents it with a one-cycle valid pulse. Operands are opaque 16-bit words (Q-format is the MAC's concern); the block performs no arithmetic on them.

---
 rtl/mac_vector_feeder.sv | 191 +++++++++++++++++++
 tb/tb_mac_vector_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_vector_feeder.sv
// -----------------------------------------------------------------------------
// mac_vector_feeder
//
// Upstream stage of the fixed-point MAC unit. Operand pairs are buffered in a
// small FIFO; each start command streams one vector of vec_len pairs into the
// MAC. The accumulator is cleared first and each pair is strobed individually.
// Once the MAC pipeline has drained, the dot-product result is captured and
// presented with a one-cycle valid pulse. Operands are treated as opaque words.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous, active-low reset
//   start      : begin one vector (sampled only while idle)
//   vec_len    : number of pairs in the vector, sampled with start
//   in_valid   : operand pair offered
//   in_ready   : FIFO can accept a pair (not full)
//   in_a, in_b : operand pair
//   mac_clr    : accumulator clear to the MAC (one cycle per vector)
//   mac_step   : mac_in1/mac_in2 hold a new pair this cycle
//   mac_in1/2  : operands to the MAC
//   mac_result : MAC accumulator output
//   dot_valid  : one-cycle pulse, dot_out valid
//   dot_out    : captured dot product, held until the next capture
//   busy       : a vector is in progress
// -----------------------------------------------------------------------------
module mac_vector_feeder #(
    parameter int DW      = 16,
    parameter int DEPTH   = 8,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic             mac_clr,
    output logic             mac_step,
    output logic [DW-1:0]    mac_in1,
    output logic [DW-1:0]    mac_in2,
    input  logic [DW-1:0]    mac_result,
    output logic             dot_valid,
    output logic [DW-1:0]    dot_out,
    output logic             busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int DRN_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // FIFO storage and pointers; the extra pointer bit separates full from empty
    logic [DW-1:0]    memA_q [DEPTH];
    logic [DW-1:0]    memB_q [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             push;
    logic             pop;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic             macStep_q, macStep_d;
    logic [DW-1:0]    macIn1_q, macIn1_d;
    logic [DW-1:0]    macIn2_q, macIn2_d;
    logic             dotValid_q, dotValid_d;
    logic [DW-1:0]    dotOut_q, dotOut_d;

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    // Readiness depends only on fullness, so a same-cycle pop never frees a slot
    assign in_ready = !fifoFull;
    assign push     = in_valid && !fifoFull;
    assign pop      = (state_q == ST_STREAM) && !fifoEmpty;

    assign wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
    assign rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;

    // Storage has no reset; only the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            memA_q[wrPtr_q[AW-1:0]] <= in_a;
            memB_q[wrPtr_q[AW-1:0]] <= in_b;
        end
    end

    // Sequencer: clear the accumulator, stream the pairs, then wait out the
    // MAC latency before capturing the result
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        macStep_d   = 1'b0;
        macIn1_d    = macIn1_q;
        macIn2_d    = macIn2_q;
        dotValid_d  = 1'b0;
        dotOut_d    = dotOut_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (vec_len != '0) begin
                        remaining_d = vec_len;
                        state_d     = ST_CLEAR;
                    end else begin
                        // An empty vector has a dot product of zero; the MAC
                        // is never touched
                        dotOut_d   = '0;
                        dotValid_d = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                state_d = ST_STREAM;
            end

            ST_STREAM: begin
                if (!fifoEmpty) begin
                    macIn1_d    = memA_q[rdPtr_q[AW-1:0]];
                    macIn2_d    = memB_q[rdPtr_q[AW-1:0]];
                    macStep_d   = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        drain_d = DRN_W'(MAC_LAT);
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (drain_q == DRN_W'(1)) begin
                    dotOut_d   = mac_result;
                    dotValid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            drain_q     <= '0;
            macStep_q   <= 1'b0;
            macIn1_q    <= '0;
            macIn2_q    <= '0;
            dotValid_q  <= 1'b0;
            dotOut_q    <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            macStep_q   <= macStep_d;
            macIn1_q    <= macIn1_d;
            macIn2_q    <= macIn2_d;
            dotValid_q  <= dotValid_d;
            dotOut_q    <= dotOut_d;
        end
    end

    assign mac_clr   = (state_q == ST_CLEAR);
    assign busy      = (state_q != ST_IDLE);
    assign mac_step  = macStep_q;
    assign mac_in1   = macIn1_q;
    assign mac_in2   = macIn2_q;
    assign dot_valid = dotValid_q;
    assign dot_out   = dotOut_q;

endmodule

// File: tb/tb_mac_vector_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_vector_feeder
//
// Directed bench for mac_vector_feeder. A small MAC model (operands as Q6.10,
// product truncated back to Q6.10 and accumulated) drives mac_result so the
// captured dot product reflects what was actually streamed. A queue tracks
// accepted pairs so every mac_step can be matched to the pair it should carry.
// -----------------------------------------------------------------------------
module tb_mac_vector_feeder;

    localparam int DW      = 16;
    localparam int DEPTH   = 8;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] vec_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_a = '0;
    logic [DW-1:0]    in_b = '0;
    logic             mac_clr;
    logic             mac_step;
    logic [DW-1:0]    mac_in1;
    logic [DW-1:0]    mac_in2;
    logic [DW-1:0]    mac_result;
    logic             dot_valid;
    logic [DW-1:0]    dot_out;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int stepCnt  = 0;
    int clrCnt   = 0;
    int dvCnt    = 0;
    int dvCyc    = -1;
    int e0       = 0;
    int stepCyc[$];
    logic [31:0] modelQ[$];

    always #5 clk = ~clk;

    mac_vector_feeder #(
        .DW(DW), .DEPTH(DEPTH), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_clr(mac_clr), .mac_step(mac_step), .mac_in1(mac_in1),
        .mac_in2(mac_in2), .mac_result(mac_result), .dot_valid(dot_valid),
        .dot_out(dot_out), .busy(busy)
    );

    // External MAC: one register stage, so a step's effect is settled well
    // before the feeder captures MAC_LAT cycles later
    logic [DW-1:0] accQ;
    logic [31:0]   prod;
    assign prod = {16'b0, mac_in1} * {16'b0, mac_in2};
    always @(posedge clk or negedge rst) begin
        if (!rst)          accQ <= '0;
        else if (mac_clr)  accQ <= '0;
        else if (mac_step) accQ <= accQ + prod[25:10];
    end
    assign mac_result = accQ;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearStats();
        stepCnt = 0;
        clrCnt  = 0;
        dvCnt   = 0;
        dvCyc   = -1;
        stepCyc.delete();
    endtask

    // One clock: sample just after the edge, match popped pairs, track pushes
    task automatic tick();
        logic          rdy;
        logic          vld;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [31:0]   pair;
        rdy = in_ready;
        vld = in_valid;
        a   = in_a;
        b   = in_b;
        @(posedge clk);
        #1;
        cycle++;
        if (mac_step) begin
            stepCnt++;
            stepCyc.push_back(cycle);
            checkOutput("step_has_pair", 32'(modelQ.size() > 0), 32'd1);
            if (modelQ.size() > 0) begin
                pair = modelQ.pop_front();
                checkOutput("mac_in1", 32'(mac_in1), 32'(pair[31:16]));
                checkOutput("mac_in2", 32'(mac_in2), 32'(pair[15:0]));
            end
        end
        if (mac_clr)   clrCnt++;
        if (dot_valid) begin
            dvCnt++;
            dvCyc = cycle;
        end
        if (vld && rdy) modelQ.push_back({a, b});
        checkOutput("in_ready", 32'(in_ready), 32'(modelQ.size() < DEPTH));
    endtask

    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic startVector(input logic [LEN_W-1:0] len);
        start   = 1'b1;
        vec_len = len;
        e0      = cycle + 1;
        tick();
        start   = 1'b0;
    endtask

    task automatic runToDot(input int budget);
        int n;
        n = 0;
        while (dvCnt == 0 && n < budget) begin
            tick();
            n++;
            if (dvCnt == 0) checkOutput("busy_active", 32'(busy), 32'd1);
        end
        checkOutput("dot_valid_seen", 32'(dvCnt), 32'd1);
        checkOutput("busy_low_at_dot", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        checkOutput("rst_mac_step", 32'(mac_step), 32'd0);
        checkOutput("rst_mac_in1", 32'(mac_in1), 32'd0);
        checkOutput("rst_mac_in2", 32'(mac_in2), 32'd0);
        checkOutput("rst_dot_valid", 32'(dot_valid), 32'd0);
        checkOutput("rst_dot_out", 32'(dot_out), 32'd0);
        checkOutput("rst_mac_clr", 32'(mac_clr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Prefilled 4-pair vector: 4 x (0x0200*0x0100 >> 10 = 0x80) = 0x0200
        $display("[TB] prefilled vector");
        clearStats();
        for (int i = 0; i < 4; i++) applyStimulus(16'h0200, 16'h0100);
        startVector(8'd4);
        checkOutput("t1_clr_after_E0", 32'(mac_clr), 32'd1);
        checkOutput("t1_busy_after_E0", 32'(busy), 32'd1);
        tick();
        checkOutput("t1_clr_one_cycle", 32'(mac_clr), 32'd0);
        checkOutput("t1_no_step_after_E1", 32'(mac_step), 32'd0);
        runToDot(20);
        checkOutput("t1_steps", 32'(stepCnt), 32'd4);
        checkOutput("t1_first_step", 32'(stepCyc[0] - e0), 32'd2);
        checkOutput("t1_last_step", 32'(stepCyc[3] - e0), 32'd5);
        checkOutput("t1_latency", 32'(dvCyc - e0), 32'd7);
        checkOutput("t1_dot_out", 32'(dot_out), 32'h0200);
        checkOutput("t1_clr_count", 32'(clrCnt), 32'd1);
        tick();
        checkOutput("t1_dv_pulse", 32'(dot_valid), 32'd0);
        checkOutput("t1_dot_hold", 32'(dot_out), 32'h0200);

        // Starved vector: one pair every 3 cycles, 3 x 0x400 = 0x0C00
        $display("[TB] starved vector");
        clearStats();
        startVector(8'd3);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'h0400, 16'h0400);
            tick();
            tick();
        end
        runToDot(20);
        checkOutput("t2_steps", 32'(stepCnt), 32'd3);
        checkOutput("t2_gap01", 32'(stepCyc[1] - stepCyc[0]), 32'd3);
        checkOutput("t2_gap12", 32'(stepCyc[2] - stepCyc[1]), 32'd3);
        checkOutput("t2_dv_after_step", 32'(dvCyc - stepCyc[2]), 32'd2);
        checkOutput("t2_latency", 32'(dvCyc - e0), 32'd10);
        checkOutput("t2_dot_out", 32'(dot_out), 32'h0C00);

        // Full FIFO: sum over k=1..8 of 0x100*k = 0x2400
        $display("[TB] full fifo");
        clearStats();
        for (int i = 0; i < 8; i++) applyStimulus(16'h0400, 16'(16'h0100 * (i + 1)));
        checkOutput("t3_full_after_8", 32'(in_ready), 32'd0);
        applyStimulus(16'hDEAD, 16'hBEEF);
        checkOutput("t3_still_full", 32'(in_ready), 32'd0);
        startVector(8'd8);
        tick();
        checkOutput("t3_full_before_pop", 32'(in_ready), 32'd0);
        tick();
        checkOutput("t3_first_pop", 32'(mac_step), 32'd1);
        checkOutput("t3_ready_after_pop", 32'(in_ready), 32'd1);
        runToDot(30);
        checkOutput("t3_steps", 32'(stepCnt), 32'd8);
        checkOutput("t3_dot_out", 32'(dot_out), 32'h2400);

        // Zero-length vector
        $display("[TB] zero-length vector");
        clearStats();
        start   = 1'b1;
        vec_len = 8'd0;
        tick();
        start   = 1'b0;
        checkOutput("t4_dot_valid", 32'(dot_valid), 32'd1);
        checkOutput("t4_dot_out", 32'(dot_out), 32'h0000);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_no_clr", 32'(mac_clr), 32'd0);
        tick();
        checkOutput("t4_dv_pulse", 32'(dot_valid), 32'd0);
        checkOutput("t4_busy_after", 32'(busy), 32'd0);
        checkOutput("t4_clr_count", 32'(clrCnt), 32'd0);
        checkOutput("t4_step_count", 32'(stepCnt), 32'd0);

        // Start pulsed mid-stream is ignored: 3 x 0x1000 = 0x3000
        $display("[TB] start while busy");
        clearStats();
        for (int i = 0; i < 3; i++) applyStimulus(16'h0800, 16'h0800);
        startVector(8'd3);
        tick();
        tick();
        start   = 1'b1;
        vec_len = 8'd5;
        tick();
        start   = 1'b0;
        runToDot(20);
        checkOutput("t5_dot_out", 32'(dot_out), 32'h3000);
        repeat (8) tick();
        checkOutput("t5_steps", 32'(stepCnt), 32'd3);
        checkOutput("t5_single_dv", 32'(dvCnt), 32'd1);
        checkOutput("t5_idle", 32'(busy), 32'd0);

        // Reset in the middle of a 6-pair stream
        $display("[TB] reset mid-stream");
        clearStats();
        for (int i = 0; i < 6; i++) applyStimulus(16'(16'h0100 * (i + 1)), 16'h0400);
        startVector(8'd6);
        tick();
        tick();
        tick();
        checkOutput("t6_streaming", 32'(mac_step), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_mac_step", 32'(mac_step), 32'd0);
        checkOutput("t6_mac_in1", 32'(mac_in1), 32'd0);
        checkOutput("t6_mac_in2", 32'(mac_in2), 32'd0);
        checkOutput("t6_dot_valid", 32'(dot_valid), 32'd0);
        checkOutput("t6_dot_out", 32'(dot_out), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_mac_clr", 32'(mac_clr), 32'd0);
        checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
        modelQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clearStats();
        tick();
        tick();
        checkOutput("t6_no_dv", 32'(dvCnt), 32'd0);
        checkOutput("t6_no_step", 32'(stepCnt), 32'd0);
        for (int i = 0; i < 2; i++) applyStimulus(16'h0400, 16'h0400);
        startVector(8'd2);
        runToDot(20);
        checkOutput("t6_steps", 32'(stepCnt), 32'd2);
        checkOutput("t6_dot_after", 32'(dot_out), 32'h0800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
